// File: rtl/delta_decoder.sv
// delta_decoder: rebuilds a sample stream from ON/OFF spike codes, with event counts and idle/error flags
module delta_decoder #(
  parameter int WIDTH      = 5,
  parameter int CNT_W      = 8,
  parameter int IDLE_LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic [WIDTH-1:0] init,
  input  logic [WIDTH-1:0] step,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       spike,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] recon,
  output logic [CNT_W-1:0] on_count,
  output logic [CNT_W-1:0] off_count,
  output logic             idle,
  output logic             err
);
  localparam int IW = $clog2(IDLE_LIMIT + 1);
  localparam logic [IW-1:0] IL = IW'(IDLE_LIMIT);
  typedef enum logic {WAIT, RUN} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] idle_cnt, idle_cnt_nxt;
  logic [WIDTH:0] sum, diff;
  logic [WIDTH-1:0] recon_nxt;
  logic accept;
  assign in_ready = ena & ~load & (state == RUN) & (~out_valid | out_ready);
  assign accept = in_valid & in_ready;
  assign sum = {1'b0, recon} + {1'b0, step};
  assign diff = {1'b0, recon} - {1'b0, step};
  // an enabled load arms the decoder; once running it never leaves RUN
  always_comb state_nxt = (ena & load) ? RUN : state;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= WAIT;
    else state <= state_nxt;
  // clamped step: carry out saturates high, borrow out saturates at zero
  always_comb
    recon_nxt = (spike == 2'b01) ? (sum[WIDTH] ? '1 : sum[WIDTH-1:0]) :
                (spike == 2'b11) ? (diff[WIDTH] ? '0 : diff[WIDTH-1:0]) : recon;
  // idle run length: cleared by load or any real spike, saturates at the limit
  always_comb
    idle_cnt_nxt = (ena & load) ? '0 :
                   (accept & spike[0]) ? '0 :
                   (accept & (spike == 2'b00) & (idle_cnt != IL)) ? idle_cnt + 1'b1 : idle_cnt;
  // datapath, statistics and output handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      recon     <= '0;
      out_valid <= 1'b0;
      on_count  <= '0;
      off_count <= '0;
      idle_cnt  <= '0;
      idle      <= 1'b0;
      err       <= 1'b0;
    end else if (ena) begin
      idle_cnt <= idle_cnt_nxt;
      idle     <= idle_cnt_nxt == IL;
      if (load) begin
        recon     <= init;
        out_valid <= 1'b0;
        err       <= 1'b0;
      end else if (accept) begin
        recon     <= recon_nxt;
        out_valid <= 1'b1;
        if (spike == 2'b01 && on_count != '1) on_count <= on_count + 1'b1;
        if (spike == 2'b11 && off_count != '1) off_count <= off_count + 1'b1;
        if (spike == 2'b10) err <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_delta_decoder.sv
// tb_delta_decoder: vector table plus scoreboard of reconstructed samples for delta_decoder
module tb_delta_decoder;
  logic clk, rst_n, ena, load, in_valid, in_ready, out_valid, out_ready, idle, err;
  logic [4:0] init, step, recon;
  logic [1:0] spike;
  logic [7:0] on_count, off_count;
  int pass_cnt = 0, tot_cnt = 0;
  int sb[$];
  typedef struct {
    int en, ld, init, step, iv, sp, ordy;
    int rdy, rc, ov, on, off, idl, er;
  } vec_t;
  vec_t tbl[18];

  delta_decoder dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .init(init), .step(step),
    .in_valid(in_valid), .in_ready(in_ready), .spike(spike), .out_valid(out_valid),
    .out_ready(out_ready), .recon(recon), .on_count(on_count), .off_count(off_count),
    .idle(idle), .err(err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void chk(string n, int a, int e);
    tot_cnt++;
    if (a == e) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endfunction

  function automatic vec_t mk(int en, int ld, int ini, int st, int iv, int sp, int ordy,
                              int rdy, int rc, int ov, int on, int off, int idl, int er);
    vec_t v;
    v.en = en; v.ld = ld; v.init = ini; v.step = st; v.iv = iv; v.sp = sp; v.ordy = ordy;
    v.rdy = rdy; v.rc = rc; v.ov = ov; v.on = on; v.off = off; v.idl = idl; v.er = er;
    return v;
  endfunction

  // consumer side: every taken sample must match the oldest expected one
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else chk("sb_recon", int'(recon), sb.pop_front());
    end

  task automatic run(input vec_t v);
    ena = v.en != 0; load = v.ld != 0; init = 5'(v.init); step = 5'(v.step);
    in_valid = v.iv != 0; spike = 2'(v.sp); out_ready = v.ordy != 0;
    @(negedge clk);
    chk("in_ready", int'(in_ready), v.rdy);
    if (v.rdy != 0 && v.iv != 0) sb.push_back(v.rc);
    @(posedge clk);
    #1;
    chk("recon", int'(recon), v.rc);
    chk("out_valid", int'(out_valid), v.ov);
    chk("on_count", int'(on_count), v.on);
    chk("off_count", int'(off_count), v.off);
    chk("idle", int'(idle), v.idl);
    chk("err", int'(err), v.er);
    if (v.ld != 0 && v.en != 0) sb.delete();
  endtask

  initial begin
    tbl[0]  = mk(1,0, 0,3,1,2'b01,1, 0, 0,0,0,0,0,0);
    tbl[1]  = mk(1,1,10,3,1,2'b01,1, 0,10,0,0,0,0,0);
    tbl[2]  = mk(1,0, 0,3,1,2'b01,1, 1,13,1,1,0,0,0);
    tbl[3]  = mk(1,0, 0,3,1,2'b01,1, 1,16,1,2,0,0,0);
    tbl[4]  = mk(1,0, 0,3,1,2'b11,1, 1,13,1,2,1,0,0);
    tbl[5]  = mk(1,0, 0,3,0,2'b00,1, 1,13,0,2,1,0,0);
    tbl[6]  = mk(1,1,30,4,0,2'b00,1, 0,30,0,2,1,0,0);
    tbl[7]  = mk(1,0, 0,4,1,2'b01,1, 1,31,1,3,1,0,0);
    tbl[8]  = mk(1,1, 2,4,0,2'b00,1, 0, 2,0,3,1,0,0);
    tbl[9]  = mk(1,0, 0,4,1,2'b11,1, 1, 0,1,3,2,0,0);
    tbl[10] = mk(1,0, 0,4,1,2'b01,0, 0, 0,1,3,2,0,0);
    tbl[11] = mk(1,0, 0,4,1,2'b01,0, 0, 0,1,3,2,0,0);
    tbl[12] = mk(1,0, 0,4,1,2'b01,1, 1, 4,1,4,2,0,0);
    tbl[13] = mk(0,1, 7,4,1,2'b01,0, 0, 4,1,4,2,0,0);
    tbl[14] = mk(1,0, 0,4,0,2'b00,1, 1, 4,0,4,2,0,0);
    tbl[15] = mk(1,0, 0,0,1,2'b11,1, 1, 4,1,4,3,0,0);
    tbl[16] = mk(1,0, 0,0,1,2'b10,1, 1, 4,1,4,3,0,1);
    tbl[17] = mk(1,1,17,0,0,2'b00,1, 0,17,0,4,3,0,0);
    rst_n = 0; ena = 0; load = 0; init = 0; step = 0; in_valid = 0; spike = 0; out_ready = 0;
    #12;
    chk("rst_recon", int'(recon), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1 rst_n = 1;
    foreach (tbl[i]) run(tbl[i]);
    for (int i = 1; i <= 16; i++) run(mk(1,0,0,0,1,2'b00,1, 1,17,1,4,3, i >= 15 ? 1 : 0, 0));
    run(mk(1,0, 0,1,1,2'b01,1, 1,18,1,5,3,0,0));
    run(mk(1,0, 0,1,1,2'b10,1, 1,18,1,5,3,0,1));
    run(mk(1,1,17,0,0,2'b00,1, 0,17,0,5,3,0,0));
    #3 rst_n = 0;
    #1;
    chk("arst_recon", int'(recon), 0);
    chk("arst_on_count", int'(on_count), 0);
    chk("arst_off_count", int'(off_count), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_err_idle", int'({err, idle}), 0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1;
    run(mk(1,0, 0,5,1,2'b01,1, 0, 0,0,0,0,0,0));
    run(mk(1,1,20,5,0,2'b00,1, 0,20,0,0,0,0,0));
    run(mk(1,0, 0,5,1,2'b11,1, 1,15,1,0,1,0,0));
    run(mk(1,0, 0,5,0,2'b00,1, 1,15,0,0,1,0,0));
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
